// File: rtl/maze_path_checker.sv
// rtl/maze_path_checker.sv - replays a maze-solver move stream and emits one path summary beat
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   move beat valid; one contiguous burst per path
//   in         move code: 0=right 1=down 2=left 3=up
//   out_valid  one-cycle summary pulse
//   steps      moves accepted in the path (saturating)
//   reversals  moves that undo the previous move (saturating)
//   row, col   final position
//   reached    final position is the far corner (MAZE_DIM-1, MAZE_DIM-1)
//   oob_err    some move in the path tried to leave the grid
// All outputs are registered and read 0 whenever out_valid is 0.

module maze_path_checker #(
  parameter int MAZE_DIM = 17,
  parameter int CNT_W    = 10,
  parameter int POS_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       in,
  output logic             out_valid,
  output logic [CNT_W-1:0] steps,
  output logic [CNT_W-1:0] reversals,
  output logic [POS_W-1:0] row,
  output logic [POS_W-1:0] col,
  output logic             reached,
  output logic             oob_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(MAZE_DIM - 1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] MV_RIGHT = 2'd0;
  localparam logic [1:0] MV_DOWN  = 2'd1;
  localparam logic [1:0] MV_LEFT  = 2'd2;
  localparam logic [1:0] MV_UP    = 2'd3;

  logic [1:0]       state;
  logic [POS_W-1:0] cur_row;
  logic [POS_W-1:0] cur_col;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] rev_cnt;
  logic [1:0]       prev_mv;
  logic             has_prev;
  logic             oob_flag;

  // Next-beat evaluation. IDLE keeps the tracking registers at their
  // cleared values, so the same logic serves the first beat of a path.
  logic             blocked;
  logic [POS_W-1:0] tgt_row;
  logic [POS_W-1:0] tgt_col;
  logic             is_rev;
  logic [CNT_W-1:0] step_nxt;
  logic [CNT_W-1:0] rev_nxt;

  always_comb begin
    blocked = 1'b0;
    tgt_row = cur_row;
    tgt_col = cur_col;
    case (in)
      MV_RIGHT: begin
        blocked = (cur_col == POS_MAX);
        tgt_col = cur_col + POS_ONE;
      end
      MV_DOWN: begin
        blocked = (cur_row == POS_MAX);
        tgt_row = cur_row + POS_ONE;
      end
      MV_LEFT: begin
        blocked = (cur_col == '0);
        tgt_col = cur_col - POS_ONE;
      end
      MV_UP: begin
        blocked = (cur_row == '0);
        tgt_row = cur_row - POS_ONE;
      end
      default: begin
        blocked = 1'b0;
      end
    endcase
  end

  always_comb begin
    // Opposite directions differ only in the upper code bit.
    is_rev   = has_prev && (in == (prev_mv ^ 2'b10));
    step_nxt = (step_cnt == CNT_MAX) ? step_cnt : step_cnt + CNT_ONE;
    rev_nxt  = rev_cnt;
    if (is_rev && (rev_cnt != CNT_MAX)) begin
      rev_nxt = rev_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cur_row   <= '0;
      cur_col   <= '0;
      step_cnt  <= '0;
      rev_cnt   <= '0;
      prev_mv   <= '0;
      has_prev  <= 1'b0;
      oob_flag  <= 1'b0;
      out_valid <= 1'b0;
      steps     <= '0;
      reversals <= '0;
      row       <= '0;
      col       <= '0;
      reached   <= 1'b0;
      oob_err   <= 1'b0;
    end else begin
      // Summary outputs are only non-zero in the pulse cycle.
      out_valid <= 1'b0;
      steps     <= '0;
      reversals <= '0;
      row       <= '0;
      col       <= '0;
      reached   <= 1'b0;
      oob_err   <= 1'b0;

      case (state)
        ST_IDLE, ST_TRACK: begin
          if (in_valid) begin
            state    <= ST_TRACK;
            step_cnt <= step_nxt;
            rev_cnt  <= rev_nxt;
            prev_mv  <= in;
            has_prev <= 1'b1;
            if (blocked) begin
              oob_flag <= 1'b1;
            end else begin
              cur_row <= tgt_row;
              cur_col <= tgt_col;
            end
          end else if (state == ST_TRACK) begin
            state <= ST_REPORT;
          end
        end

        ST_REPORT: begin
          // Beats arriving here are dropped; the summary is captured and the
          // tracking registers return to the start-of-path values.
          out_valid <= 1'b1;
          steps     <= step_cnt;
          reversals <= rev_cnt;
          row       <= cur_row;
          col       <= cur_col;
          reached   <= (cur_row == POS_MAX) && (cur_col == POS_MAX);
          oob_err   <= oob_flag;
          cur_row   <= '0;
          cur_col   <= '0;
          step_cnt  <= '0;
          rev_cnt   <= '0;
          prev_mv   <= '0;
          has_prev  <= 1'b0;
          oob_flag  <= 1'b0;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maze_path_checker.sv
// tb/tb_maze_path_checker.sv - table-driven self-check of maze_path_checker

module tb_maze_path_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_mv = 2'd0;

  logic       out_valid;
  logic [9:0] steps;
  logic [9:0] reversals;
  logic [4:0] row;
  logic [4:0] col;
  logic       reached;
  logic       oob_err;

  logic       s_out_valid;
  logic [3:0] s_steps;
  logic [3:0] s_reversals;
  logic [4:0] s_row;
  logic [4:0] s_col;
  logic       s_reached;
  logic       s_oob_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  maze_path_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_mv),
    .out_valid(out_valid), .steps(steps), .reversals(reversals),
    .row(row), .col(col), .reached(reached), .oob_err(oob_err)
  );

  maze_path_checker #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_mv),
    .out_valid(s_out_valid), .steps(s_steps), .reversals(s_reversals),
    .row(s_row), .col(s_col), .reached(s_reached), .oob_err(s_oob_err)
  );

  typedef struct {
    string       name;
    logic [79:0] mv;
    int          n;
    int          e_steps;
    int          e_rev;
    int          e_row;
    int          e_col;
    int          e_reached;
    int          e_oob;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic app(inout logic [79:0] m, inout int n, input int d, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      m[2*n +: 2] = 2'(d);
      n++;
    end
  endtask

  function automatic int sat4(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic send_beats(input logic [79:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_mv    = m[2*i +: 2];
    end
  endtask

  // Drops in_valid and expects the summary pulse on the third sampling
  // point: TRACK (last beat), REPORT, then the registered pulse.
  task automatic end_and_check(input vec_t v);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      chk({v.name, "_timeout"}, 0, 1);
    end else begin
      chk({v.name, "_latency"}, lat, 3);
      chk({v.name, "_steps"}, int'(steps), v.e_steps);
      chk({v.name, "_rev"}, int'(reversals), v.e_rev);
      chk({v.name, "_row"}, int'(row), v.e_row);
      chk({v.name, "_col"}, int'(col), v.e_col);
      chk({v.name, "_reached"}, int'(reached), v.e_reached);
      chk({v.name, "_oob"}, int'(oob_err), v.e_oob);
      chk({v.name, "_small_valid"}, int'(s_out_valid), 1);
      chk({v.name, "_small_steps"}, int'(s_steps), sat4(v.e_steps));
      chk({v.name, "_small_rev"}, int'(s_reversals), sat4(v.e_rev));
      @(negedge clk);
      chk({v.name, "_pulse_end"},
          int'({out_valid, steps, reversals, row, col, reached, oob_err}), 0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    send_beats(v.mv, v.n);
    end_and_check(v);
  endtask

  function automatic vec_t mk(input string nm, input logic [79:0] m, input int n,
                              input int es, input int er, input int erow,
                              input int ecol, input int ereach, input int eoob);
    vec_t v;
    v.name = nm; v.mv = m; v.n = n;
    v.e_steps = es; v.e_rev = er; v.e_row = erow; v.e_col = ecol;
    v.e_reached = ereach; v.e_oob = eoob;
    return v;
  endfunction

  initial begin
    logic [79:0] m;
    int          n;
    int          seen;
    vec_t        v;

    // Moves: 0=R 1=D 2=L 3=U
    m = '0; n = 0; app(m, n, 0, 16); app(m, n, 1, 16);
    vecs[0] = mk("corner_32", m, n, 32, 0, 16, 16, 1, 0);
    m = '0; n = 0; app(m, n, 3, 1);
    vecs[1] = mk("single_up", m, n, 1, 0, 0, 0, 0, 1);
    m = '0; n = 0; app(m, n, 0, 1); app(m, n, 2, 1); app(m, n, 0, 1); app(m, n, 1, 1);
    vecs[2] = mk("rlrd", m, n, 4, 2, 1, 1, 0, 0);
    m = '0; n = 0; for (int i = 0; i < 10; i++) begin app(m, n, 0, 1); app(m, n, 2, 1); end
    vecs[3] = mk("alt20", m, n, 20, 19, 0, 0, 0, 0);
    m = '0; n = 0; app(m, n, 0, 16); app(m, n, 1, 16); app(m, n, 2, 1);
    vecs[4] = mk("pass_goal", m, n, 33, 0, 16, 15, 0, 0);
    m = '0; n = 0; app(m, n, 0, 17); app(m, n, 1, 17);
    vecs[5] = mk("edge_oob", m, n, 34, 0, 16, 16, 1, 1);
    m = '0; n = 0; app(m, n, 3, 1); app(m, n, 0, 1);
    vecs[6] = mk("oob_sticky", m, n, 2, 0, 0, 1, 0, 1);
    m = '0; n = 0; app(m, n, 1, 1); app(m, n, 3, 1); app(m, n, 2, 1);
    vecs[7] = mk("dul", m, n, 3, 1, 0, 0, 0, 1);
    m = '0; n = 0; app(m, n, 2, 1); app(m, n, 0, 1);
    vecs[8] = mk("rev_after_oob", m, n, 2, 1, 0, 1, 0, 1);

    // Reset state
    @(negedge clk);
    chk("reset_outputs",
        int'({out_valid, steps, reversals, row, col, reached, oob_err}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs",
        int'({out_valid, steps, reversals, row, col, reached, oob_err}), 0);

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
    end

    // Reset in the middle of a 5-beat burst aborts the path.
    m = '0; n = 0; app(m, n, 0, 3);
    send_beats(m, n);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_mv = 2'd0;
    @(negedge clk);
    chk("rst_mid_outputs", int'({out_valid, steps, col}), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_abort_no_pulse", seen, 0);
    m = '0; n = 0; app(m, n, 1, 2);
    run_vec(mk("after_rst", m, n, 2, 0, 2, 0, 0, 0));

    // A beat presented in the REPORT cycle is dropped.
    m = '0; n = 0; app(m, n, 0, 2);
    send_beats(m, n);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mv = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("drop_valid", int'(out_valid), 1);
    chk("drop_steps", int'(steps), 2);
    chk("drop_row", int'(row), 0);
    chk("drop_col", int'(col), 2);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("drop_no_extra_pulse", seen, 0);
    m = '0; n = 0; app(m, n, 1, 1);
    run_vec(mk("after_drop", m, n, 1, 0, 1, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
